alu_arbiter: RTL and testbench

Two-requester arbiter that shares one combinational 32-bit ALU between the execute stage (requester 0) and an auxiliary unit such as a multiply/divide sequencer or address generator (requester 1). Each requester issues operand/opcode transactions on a valid/ready channel. The arbiter grants one transaction per cycle, round-robin on contention, and returns a registered result tagged with the requester id on a single response channel with backpressure.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_core.sv | 38 +++
 rtl/alu_arbiter.sv | 105 ++++++++++
 tb/tb_alu_arbiter.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: the opcode encoding,
// the datapath width, the shift-amount width and the arbiter FSM states.
package alu_pkg;

   localparam int ALU_W   = 32;
   localparam int SHAMT_W = 5;

   typedef enum logic [3:0] {
      OP_ADD  = 4'b0000,
      OP_SUB  = 4'b1000,
      OP_SLL  = 4'b0001,
      OP_SLT  = 4'b0010,
      OP_SLTU = 4'b0011,
      OP_XOR  = 4'b0100,
      OP_SRL  = 4'b0101,
      OP_SRA  = 4'b1101,
      OP_OR   = 4'b0110,
      OP_AND  = 4'b0111
   } alu_op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_HOLD = 1'b1
   } arb_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU shared by both requesters. Shift amounts come
// from the low bits of operand b; unknown opcodes quietly produce zero.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_W
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [3:0]       i_op,
   output logic [WIDTH-1:0] o_y
);

   alu_op_e             w_op;
   logic [SHAMT_W-1:0]  w_shamt;

   assign w_op    = alu_op_e'(i_op);
   assign w_shamt = i_b[SHAMT_W-1:0];

   // Opcode decode; anything outside the table falls to the zero default.
   always_comb begin
      o_y = '0;
      case (w_op)
         OP_ADD:  o_y = i_a + i_b;
         OP_SUB:  o_y = i_a - i_b;
         OP_SLL:  o_y = i_a << w_shamt;
         OP_SLT:  o_y = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
         OP_SLTU: o_y = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
         OP_XOR:  o_y = i_a ^ i_b;
         OP_SRL:  o_y = i_a >> w_shamt;
         OP_SRA:  o_y = $unsigned($signed(i_a) >>> w_shamt);
         OP_OR:   o_y = i_a | i_b;
         OP_AND:  o_y = i_a & i_b;
         default: o_y = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared ALU. One
// transaction is granted per cycle and its result is held in a single
// response register, tagged with the owning requester, until consumed.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             r0_valid,
   output logic             r0_ready,
   input  logic [WIDTH-1:0] r0_a,
   input  logic [WIDTH-1:0] r0_b,
   input  logic [3:0]       r0_op,
   input  logic             r1_valid,
   output logic             r1_ready,
   input  logic [WIDTH-1:0] r1_a,
   input  logic [WIDTH-1:0] r1_b,
   input  logic [3:0]       r1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_data
);

   arb_state_e       r_state;
   arb_state_e       w_nextState;
   logic             r_last;
   logic             r_rspId;
   logic [WIDTH-1:0] r_rspData;

   logic             w_canAccept;
   logic             w_grant1;
   logic             w_accept;
   logic [WIDTH-1:0] w_aluA;
   logic [WIDTH-1:0] w_aluB;
   logic [3:0]       w_aluOp;
   logic [WIDTH-1:0] w_aluY;

   // Requester 1 wins when it is the only one asking, or on a tie when
   // requester 0 was served last; otherwise the grant rests on requester 0.
   assign w_grant1    = r1_valid & (~r0_valid | ~r_last);
   assign w_canAccept = (r_state == ST_IDLE) | ((r_state == ST_HOLD) & rsp_ready);
   assign w_accept    = (r0_valid & r0_ready) | (r1_valid & r1_ready);

   assign w_aluA  = w_grant1 ? r1_a  : r0_a;
   assign w_aluB  = w_grant1 ? r1_b  : r0_b;
   assign w_aluOp = w_grant1 ? r1_op : r0_op;

   alu_core #(
      .WIDTH (WIDTH)
   ) u_aluCore (
      .i_a  (w_aluA),
      .i_b  (w_aluB),
      .i_op (w_aluOp),
      .o_y  (w_aluY)
   );

   // FSM state register; reset drops any pending result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next state: fill on accept, drain when the consumer takes the result
   // and no replacement arrives in the same cycle.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_nextState = ST_HOLD;
         ST_HOLD: if (rsp_ready && !w_accept) w_nextState = ST_IDLE;
         default: w_nextState = ST_IDLE;
      endcase
   end

   // Outputs: readies are suppressed while reset is held so nothing is
   // handshaken into a register that is about to be cleared.
   always_comb begin
      rsp_valid = (r_state == ST_HOLD);
      r0_ready  = ~rst & w_canAccept & ~w_grant1;
      r1_ready  = ~rst & w_canAccept & w_grant1;
   end

   // Result register and round-robin history; both move only on an accept
   // so the response stays stable under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rspData <= '0;
         r_rspId   <= 1'b0;
         r_last    <= 1'b1;
      end else if (w_accept) begin
         r_rspData <= w_aluY;
         r_rspId   <= w_grant1;
         r_last    <= w_grant1;
      end
   end

   assign rsp_id   = r_rspId;
   assign rsp_data = r_rspData;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: the driver pushes the hand-computed
// response of every transaction it expects to be accepted, and a monitor
// pops and compares whenever a response is handed over.
module tb_alu_arbiter;

   typedef struct packed {
      logic        id;
      logic [31:0] data;
   } rsp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        r0_valid, r0_ready, r1_valid, r1_ready;
   logic [31:0] r0_a, r0_b, r1_a, r1_b;
   logic [3:0]  r0_op, r1_op;
   logic        rsp_valid, rsp_ready, rsp_id;
   logic [31:0] rsp_data;

   int   checks = 0;
   int   errors = 0;
   rsp_t expQ[$];

   alu_arbiter #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .r0_valid  (r0_valid),
      .r0_ready  (r0_ready),
      .r0_a      (r0_a),
      .r0_b      (r0_b),
      .r0_op     (r0_op),
      .r1_valid  (r1_valid),
      .r1_ready  (r1_ready),
      .r1_a      (r1_a),
      .r1_b      (r1_b),
      .r1_op     (r1_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Single comparison with failure reporting.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Drive one cycle of requests; expGrant is -1 when no accept is expected.
   task automatic applyStimulus(
      input logic v0, input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
      input logic v1, input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
      input logic rr, input int expGrant, input logic [31:0] expData);
      rsp_t e;
      @(negedge clk);
      r0_valid = v0; r0_op = op0; r0_a = a0; r0_b = b0;
      r1_valid = v1; r1_op = op1; r1_a = a1; r1_b = b1;
      rsp_ready = rr;
      #2;
      checkOutput("r0Accept", {31'b0, r0_ready & r0_valid}, {31'b0, expGrant == 0});
      checkOutput("r1Accept", {31'b0, r1_ready & r1_valid}, {31'b0, expGrant == 1});
      if (expGrant >= 0) begin
         e.id   = expGrant[0];
         e.data = expData;
         expQ.push_back(e);
      end
   endtask

   // One cycle with no requests.
   task automatic idleCycle(input logic rr);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, rr, -1, 32'h0);
   endtask

   // Monitor: just before each rising edge, a handed-over response is
   // compared against the oldest expectation.
   always begin
      rsp_t e;
      @(negedge clk);
      #4;
      if (!rst && rsp_valid && rsp_ready) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedRsp: got id %0d data 0x%08h, expected no response", rsp_id, rsp_data);
         end else begin
            e = expQ.pop_front();
            checkOutput("rspId", {31'b0, rsp_id}, {31'b0, e.id});
            checkOutput("rspData", rsp_data, e.data);
         end
      end
   end

   initial begin
      // Reset with both requesters asking and the consumer ready.
      rst = 1'b1;
      r0_valid = 1'b1; r0_op = 4'h0; r0_a = 32'd1; r0_b = 32'd1;
      r1_valid = 1'b1; r1_op = 4'h0; r1_a = 32'd1; r1_b = 32'd1;
      rsp_ready = 1'b1;
      @(negedge clk);
      #2;
      checkOutput("resetRspValid", {31'b0, rsp_valid}, 32'h0);
      checkOutput("resetRspId", {31'b0, rsp_id}, 32'h0);
      checkOutput("resetRspData", rsp_data, 32'h0);
      checkOutput("resetR0Ready", {31'b0, r0_ready}, 32'h0);
      checkOutput("resetR1Ready", {31'b0, r1_ready}, 32'h0);
      @(negedge clk);
      rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;

      // Single ops on r0, then one-cycle latency check.
      applyStimulus(1'b1, 4'b0000, 32'd5, 32'd7, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 0, 32'd12);
      applyStimulus(1'b1, 4'b1000, 32'd3, 32'd5, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 0, 32'hFFFFFFFE);
      checkOutput("latencyValid", {31'b0, rsp_valid}, 32'h1);
      checkOutput("latencyData", rsp_data, 32'd12);
      idleCycle(1'b1);
      idleCycle(1'b1);
      checkOutput("drainedValid", {31'b0, rsp_valid}, 32'h0);

      // Opcode sweep on r1, back to back.
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b1101, 32'h80000000, 32'd4, 1'b1, 1, 32'hF8000000);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0101, 32'h80000000, 32'd4, 1'b1, 1, 32'h08000000);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0010, 32'h80000000, 32'd4, 1'b1, 1, 32'h1);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0011, 32'h80000000, 32'd4, 1'b1, 1, 32'h0);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b1111, 32'h80000000, 32'd4, 1'b1, 1, 32'h0);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b1101, 32'h40000000, 32'd4, 1'b1, 1, 32'h04000000);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0001, 32'h1, 32'h23, 1'b1, 1, 32'h8);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1, 32'h0FF00FF0);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1, 32'hFFF0FFF0);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1, 32'hF000F000);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'hFFFFFFFF, 32'h1, 1'b1, 1, 32'h0);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0010, 32'hFFFFFFFF, 32'h1, 1'b1, 1, 32'h1);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0011, 32'hFFFFFFFF, 32'h1, 1'b1, 1, 32'h0);
      idleCycle(1'b1);

      // Contention after a fresh reset: grants alternate starting with r0.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 4'b0000, 32'd10, 32'd1, 1'b1, 4'b1000, 32'd10, 32'd1,
                       1'b1, i % 2, (i % 2 == 0) ? 32'd11 : 32'd9);
      end
      idleCycle(1'b1);

      // Backpressure: result held stable, nothing accepted, then a
      // delivery and a new r1 accept in the same cycle.
      applyStimulus(1'b1, 4'b0000, 32'd100, 32'd1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 0, 32'd101);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 4'b0000, 32'd7, 32'd7, 1'b1, 4'b0000, 32'd8, 32'd8, 1'b0, -1, 32'h0);
         checkOutput("stallR0Ready", {31'b0, r0_ready}, 32'h0);
         checkOutput("stallR1Ready", {31'b0, r1_ready}, 32'h0);
         checkOutput("stallData", rsp_data, 32'd101);
         checkOutput("stallId", {31'b0, rsp_id}, 32'h0);
      end
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0100, 32'hFF, 32'h0F, 1'b1, 1, 32'hF0);
      idleCycle(1'b1);
      checkOutput("noBubbleValid", {31'b0, rsp_valid}, 32'h1);
      checkOutput("noBubbleId", {31'b0, rsp_id}, 32'h1);
      idleCycle(1'b1);

      // Reset mid-operation: pending result is discarded.
      applyStimulus(1'b1, 4'b0000, 32'd1, 32'd1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 0, 32'd2);
      @(negedge clk);
      rst = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1; rsp_ready = 1'b0;
      expQ.delete();
      #2;
      checkOutput("midRstR0Ready", {31'b0, r0_ready}, 32'h0);
      checkOutput("midRstR1Ready", {31'b0, r1_ready}, 32'h0);
      @(negedge clk);
      rst = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0;
      #1;
      checkOutput("midRstValid", {31'b0, rsp_valid}, 32'h0);
      checkOutput("midRstData", rsp_data, 32'h0);
      checkOutput("midRstId", {31'b0, rsp_id}, 32'h0);
      applyStimulus(1'b1, 4'b0000, 32'd2, 32'd3, 1'b1, 4'b0000, 32'd7, 32'd7, 1'b1, 0, 32'd5);
      idleCycle(1'b1);

      // Withdrawn r1 request during a stall never produces a response.
      applyStimulus(1'b1, 4'b0000, 32'd20, 32'd22, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 0, 32'd42);
      applyStimulus(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'd1, 32'd1, 1'b0, -1, 32'h0);
      idleCycle(1'b0);
      idleCycle(1'b1);
      for (int i = 0; i < 4; i++) idleCycle(1'b1);

      checkOutput("queueEmpty", expQ.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
